// File: rtl/fifo_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_burst_reader_pkg
//  Purpose  : Shared types for the FIFO burst reader.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_burst_reader_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

endpackage : fifo_burst_reader_pkg
`default_nettype wire

// File: rtl/fifo_burst_reader_skid.sv
`default_nettype none
// ============================================================================
//  Module   : stream_skid_buffer
//  Purpose  : Two-entry (main + skid) registered valid/ready buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_full,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   logic             r_main_valid;
   logic [WIDTH-1:0] r_main_data;
   logic             r_skid_valid;
   logic [WIDTH-1:0] r_skid_data;
   logic             w_pop;

   assign w_pop     = r_main_valid & out_ready;
   // Registered full flag: the writer stops one entry early, so the skid absorbs the in-flight word.
   assign in_full   = r_skid_valid;
   assign out_valid = r_main_valid;
   assign out_data  = r_main_data;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         r_main_valid <= 1'b0;
         r_main_data  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
      end else if (w_pop) begin
         if (r_skid_valid) begin
            r_main_valid <= 1'b1;
            r_main_data  <= r_skid_data;
            r_skid_valid <= in_valid;
            if (in_valid)
               r_skid_data <= in_data;
         end else begin
            r_main_valid <= in_valid;
            if (in_valid)
               r_main_data <= in_data;
         end
      end else if (in_valid) begin
         if (r_main_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
         end else begin
            r_main_valid <= 1'b1;
            r_main_data  <= in_data;
         end
      end
   end

endmodule : stream_skid_buffer
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_burst_reader
//  Purpose  : Drains fixed-size bursts from a show-ahead FIFO into a sop/eop stream.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int BURST = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clear,
   input  logic [$clog2(DEPTH+1)-1:0] fifo_used,
   input  logic [WIDTH-1:0]           fifo_data,
   input  logic                       fifo_empty,
   output logic                       fifo_ack,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_sop,
   output logic                       o_eop,
   output logic                       o_valid,
   input  logic                       o_ready,
   output logic                       busy
);

   localparam int                    c_USED_W     = $clog2(DEPTH + 1);
   localparam int                    c_CNT_W      = $clog2(BURST + 1);
   localparam logic [c_USED_W-1:0]   c_BURST_USED = c_USED_W'(BURST);
   localparam logic [c_CNT_W-1:0]    c_LAST       = c_CNT_W'(BURST - 1);

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_busy;
   logic                w_skid_full;
   logic                w_ack;
   logic [WIDTH+1:0]    w_out_word;

   // Reset and clear mask the ack so no word is popped and then discarded by the flush.
   assign w_ack    = (r_state == ST_BURST) & reset_n & ~clear & ~fifo_empty & ~w_skid_full;
   assign fifo_ack = w_ack;
   assign busy     = r_busy;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (fifo_used >= c_BURST_USED) begin
                  r_state <= ST_BURST;
                  r_busy  <= 1'b1;
               end
            end
            ST_BURST: begin
               if (w_ack) begin
                  if (r_cnt == c_LAST) begin
                     r_cnt   <= '0;
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + c_CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   stream_skid_buffer #(
      .WIDTH (WIDTH + 2)
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .in_valid  (w_ack),
      .in_data   ({(r_cnt == '0), (r_cnt == c_LAST), fifo_data}),
      .in_full   (w_skid_full),
      .out_valid (o_valid),
      .out_data  (w_out_word),
      .out_ready (o_ready)
   );

   assign o_sop  = w_out_word[WIDTH+1];
   assign o_eop  = w_out_word[WIDTH];
   assign o_data = w_out_word[WIDTH-1:0];

endmodule : fifo_burst_reader
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_burst_reader
//  Purpose  : Directed bench for fifo_burst_reader (BURST=4 and BURST=1) with FIFO models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

   logic       clk = 1'b0;
   logic       reset_n, clear, o_ready, flush;
   logic       wr0, wr1;
   logic [7:0] wd;

   logic [3:0] used0, used1;
   logic [7:0] fdata0, fdata1, odata0, odata1;
   logic       empty0, empty1, ack0, ack1;
   logic       sop0, sop1, eop0, eop1, valid0, valid1, busy0, busy1;

   logic [7:0] mem0 [8];
   logic [7:0] mem1 [8];
   logic [2:0] wp0, rp0, wp1, rp1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Show-ahead FIFO models, depth 8
   assign fdata0 = mem0[rp0];
   assign empty0 = (used0 == 4'd0);
   assign fdata1 = mem1[rp1];
   assign empty1 = (used1 == 4'd0);

   always @(posedge clk) begin
      if (flush) begin
         wp0 <= '0; rp0 <= '0; used0 <= '0;
         wp1 <= '0; rp1 <= '0; used1 <= '0;
      end else begin
         if (wr0 && used0 < 4'd8) begin mem0[wp0] <= wd; wp0 <= wp0 + 3'd1; end
         if (ack0 && !empty0) rp0 <= rp0 + 3'd1;
         used0 <= used0 + {3'b0, (wr0 && used0 < 4'd8)} - {3'b0, (ack0 && !empty0)};
         if (wr1 && used1 < 4'd8) begin mem1[wp1] <= wd; wp1 <= wp1 + 3'd1; end
         if (ack1 && !empty1) rp1 <= rp1 + 3'd1;
         used1 <= used1 + {3'b0, (wr1 && used1 < 4'd8)} - {3'b0, (ack1 && !empty1)};
      end
   end

   fifo_burst_reader #(.WIDTH(8), .DEPTH(8), .BURST(4)) dut0 (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .fifo_used(used0), .fifo_data(fdata0), .fifo_empty(empty0), .fifo_ack(ack0),
      .o_data(odata0), .o_sop(sop0), .o_eop(eop0), .o_valid(valid0), .o_ready(o_ready),
      .busy(busy0)
   );

   fifo_burst_reader #(.WIDTH(8), .DEPTH(8), .BURST(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .fifo_used(used1), .fifo_data(fdata1), .fifo_empty(empty1), .fifo_ack(ack1),
      .o_data(odata1), .o_sop(sop1), .o_eop(eop1), .o_valid(valid1), .o_ready(o_ready),
      .busy(busy1)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks the visible stream word {valid,sop,eop,data} of dut0
   task automatic out0(input string tag, input logic sop, input logic eop, input logic [7:0] d);
      chk(tag, {valid0, sop0, eop0, odata0}, {1'b1, sop, eop, d});
   endtask

   task automatic push0(input logic [7:0] d);
      wr0 = 1'b1; wd = d; step(); wr0 = 1'b0;
   endtask

   task automatic push1(input logic [7:0] d);
      wr1 = 1'b1; wd = d; step(); wr1 = 1'b0;
   endtask

   initial begin
      int         ack_t[$];
      logic [9:0] words[$];

      reset_n = 1'b0; clear = 1'b0; o_ready = 1'b0; flush = 1'b1;
      wr0 = 1'b0; wr1 = 1'b0; wd = 8'h00;
      repeat (3) step();
      chk("reset_dut0", {valid0, sop0, eop0, odata0, ack0, busy0}, 32'h0);
      chk("reset_dut1", {valid1, sop1, eop1, odata1, ack1, busy1}, 32'h0);
      flush = 1'b0; reset_n = 1'b1;
      step();

      // 1: below threshold nothing happens; fourth word starts a full-rate burst
      o_ready = 1'b1;
      push0(8'hA0); push0(8'hA1); push0(8'hA2);
      chk("t1_no_ack_3w", ack0, 1'b0);
      chk("t1_no_valid_3w", valid0, 1'b0);
      step(); step();
      chk("t1_still_idle", {ack0, valid0, busy0}, 3'b000);
      push0(8'hA3);
      step();
      chk("t1_first_ack", {ack0, busy0, valid0}, 3'b110);
      step(); out0("t1_w0", 1'b1, 1'b0, 8'hA0); chk("t1_ack2", ack0, 1'b1);
      step(); out0("t1_w1", 1'b0, 1'b0, 8'hA1); chk("t1_ack3", ack0, 1'b1);
      step(); out0("t1_w2", 1'b0, 1'b0, 8'hA2); chk("t1_ack4", ack0, 1'b1);
      step(); out0("t1_w3", 1'b0, 1'b1, 8'hA3); chk("t1_done", {ack0, busy0}, 2'b00);
      step(); chk("t1_drained", valid0, 1'b0);

      // 2: backpressure stops popping after two words
      o_ready = 1'b0;
      push0(8'hB0); push0(8'hB1); push0(8'hB2); push0(8'hB3);
      step(); chk("t2_ack1", ack0, 1'b1);
      step(); out0("t2_b0", 1'b1, 1'b0, 8'hB0); chk("t2_ack2", ack0, 1'b1);
      step(); out0("t2_b0_hold", 1'b1, 1'b0, 8'hB0); chk("t2_ack_stop", ack0, 1'b0);
      step(); out0("t2_b0_hold2", 1'b1, 1'b0, 8'hB0); chk("t2_ack_stop2", ack0, 1'b0);
      chk("t2_fifo_used", used0, 4'd2);
      o_ready = 1'b1;
      step(); out0("t2_b1", 1'b0, 1'b0, 8'hB1); chk("t2_ack_resume", ack0, 1'b1);
      step(); out0("t2_b2", 1'b0, 1'b0, 8'hB2);
      step(); out0("t2_b3", 1'b0, 1'b1, 8'hB3); chk("t2_done", {ack0, busy0}, 2'b00);
      step(); chk("t2_drained", valid0, 1'b0);

      // 3: eight preloaded words form two bursts separated by one idle cycle
      clear = 1'b1;
      for (int k = 0; k < 8; k++) push0(8'hC0 + 8'(k));
      clear = 1'b0;
      ack_t.delete(); words.delete();
      for (int c = 0; c < 30; c++) begin
         step();
         if (ack0) ack_t.push_back(c);
         if (valid0) words.push_back({sop0, eop0, odata0});
      end
      chk("t3_n_words", words.size(), 8);
      chk("t3_n_acks", ack_t.size(), 8);
      for (int k = 0; k < 8; k++)
         chk($sformatf("t3_word%0d", k), (k < words.size()) ? words[k] : 10'h3FF,
             {(k % 4 == 0), (k % 4 == 3), 8'hC0 + 8'(k)});
      if (ack_t.size() >= 5) begin
         chk("t3_burst_run", ack_t[3] - ack_t[0], 3);
         chk("t3_idle_gap", ack_t[4] - ack_t[3], 2);
      end

      // 4: reset mid-burst leaves two words in the FIFO
      clear = 1'b1;
      push0(8'hD0); push0(8'hD1); push0(8'hD2); push0(8'hD3);
      clear = 1'b0;
      step(); chk("t4_ack", ack0, 1'b1);
      step(); out0("t4_d0", 1'b1, 1'b0, 8'hD0);
      step(); out0("t4_d1", 1'b0, 1'b0, 8'hD1);
      reset_n = 1'b0;
      step();
      chk("t4_reset_outs", {valid0, sop0, eop0, odata0, ack0, busy0}, 32'h0);
      chk("t4_used", used0, 4'd2);
      reset_n = 1'b1;
      step(); step(); step();
      chk("t4_no_ack", {ack0, busy0, valid0}, 3'b000);
      chk("t4_used_after", used0, 4'd2);

      // 5: clear discards a buffered word
      o_ready = 1'b0;
      push0(8'hE0); push0(8'hE1);
      step(); chk("t5_ack", ack0, 1'b1);
      step(); out0("t5_d2", 1'b1, 1'b0, 8'hD2);
      clear = 1'b1;
      step();
      chk("t5_cleared", {valid0, ack0, busy0}, 3'b000);
      chk("t5_used", used0, 4'd3);
      clear = 1'b0; o_ready = 1'b1;
      step(); step(); step();
      chk("t5_never_emitted", {valid0, busy0}, 2'b00);

      // 6: BURST=1 gives single-word packets with an idle cycle between
      clear = 1'b1;
      push1(8'hF0); push1(8'hF1); push1(8'hF2);
      clear = 1'b0;
      ack_t.delete(); words.delete();
      for (int c = 0; c < 15; c++) begin
         step();
         if (ack1) ack_t.push_back(c);
         if (valid1) words.push_back({sop1, eop1, odata1});
      end
      chk("t6_n_words", words.size(), 3);
      for (int k = 0; k < 3; k++)
         chk($sformatf("t6_word%0d", k), (k < words.size()) ? words[k] : 10'h000,
             {2'b11, 8'hF0 + 8'(k)});
      if (ack_t.size() >= 3) begin
         chk("t6_gap01", ack_t[1] - ack_t[0], 2);
         chk("t6_gap12", ack_t[2] - ack_t[1], 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_fifo_burst_reader
`default_nettype wire
